// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-mode enum, opcode constants and fusion FSM states
package imm_pkg;
    typedef enum logic [2:0] {
        SEXT   = 3'd0,
        ZEXT   = 3'd1,
        LUI    = 3'd2,
        BRANCH = 3'd3,
        JUMP   = 3'd4
    } imm_mode_e;
    localparam logic [5:0] OP_LUI = 6'h0F;
    localparam logic [5:0] OP_ORI = 6'h0D;
    typedef enum logic {IDLE, PEND} fuse_state_e;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational extension / branch / jump target generator
// Ports: i_instruction, i_imm_mode, i_pc_plus4 in; o_value (DATA_W), o_err (reserved mode) out
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       i_instruction,
    input  logic [2:0]        i_imm_mode,
    input  logic [DATA_W-1:0] i_pc_plus4,
    output logic [DATA_W-1:0] o_value,
    output logic              o_err
);
    logic [15:0]       w_imm;
    logic [63:0]       w_sext64;
    logic [63:0]       w_lui64;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_branch;
    logic [DATA_W-1:0] w_jump;
    logic              w_unused;
    assign w_imm    = i_instruction[15:0];
    // Build at 64 bits and truncate so DATA_W=32 needs no zero-width replication
    assign w_sext64 = {{48{w_imm[15]}}, w_imm};
    assign w_lui64  = {{32{w_imm[15]}}, w_imm, 16'h0};
    assign w_sext   = w_sext64[DATA_W-1:0];
    assign w_lui    = w_lui64[DATA_W-1:0];
    assign w_branch = i_pc_plus4 + (w_sext << 2);
    assign w_jump   = {i_pc_plus4[DATA_W-1:28], i_instruction[25:0], 2'b00};
    assign w_unused = &{1'b0, i_instruction[31:26]};
    always_comb begin
        o_value = (i_imm_mode == 3'(SEXT))   ? w_sext :
                  (i_imm_mode == 3'(ZEXT))   ? DATA_W'(w_imm) :
                  (i_imm_mode == 3'(LUI))    ? w_lui :
                  (i_imm_mode == 3'(BRANCH)) ? w_branch :
                  (i_imm_mode == 3'(JUMP))   ? w_jump : '0;
        o_err   = i_imm_mode > 3'(JUMP);
    end
endmodule

// File: rtl/imm_unit.sv
// imm_unit: registered, handshaked immediate generator with optional LUI+ORI fusion
// Ports: i_clk, i_reset (sync, active-high); i_in_valid/o_in_ready, i_instruction, i_imm_mode,
//        i_pc_plus4, i_drain in; o_out_valid/i_out_ready, o_imm_out, o_out_rd, o_out_fused, o_out_err out
// Build option: define LUI_FUSE_EN to build the LUI/ORI fusion FSM (otherwise drain is ignored)
module imm_unit
    import imm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [31:0]       i_instruction,
    input  logic [2:0]        i_imm_mode,
    input  logic [DATA_W-1:0] i_pc_plus4,
    input  logic              i_drain,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_imm_out,
    output logic [4:0]        o_out_rd,
    output logic              o_out_fused,
    output logic              o_out_err
);
    logic [DATA_W-1:0] w_ext;
    logic              w_ext_err;
    logic [4:0]        w_rt;
    logic              w_slot_free;
    logic              w_load;
    logic [DATA_W-1:0] w_val;
    logic [4:0]        w_rd;
    logic              w_fused;
    logic              w_err;
    logic              r_valid;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rd;
    logic              r_fused;
    logic              r_err;
    assign w_rt        = i_instruction[20:16];
    assign w_slot_free = !r_valid || i_out_ready;
    imm_ext_core #(.DATA_W(DATA_W)) u_core (
        .i_instruction(i_instruction),
        .i_imm_mode   (i_imm_mode),
        .i_pc_plus4   (i_pc_plus4),
        .o_value      (w_ext),
        .o_err        (w_ext_err)
    );
`ifdef LUI_FUSE_EN
    fuse_state_e       r_state;
    fuse_state_e       w_next;
    logic [DATA_W-1:0] r_upper;
    logic [4:0]        r_prd;
    logic              w_match;
    logic              w_capture;
    logic              w_in_ready;
    assign w_match = i_in_valid && i_instruction[31:26] == OP_ORI && i_imm_mode == 3'(ZEXT)
                     && i_instruction[25:21] == r_prd && w_rt == r_prd;
    assign o_in_ready = w_in_ready;
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_capture  = 1'b0;
        w_val      = w_ext;
        w_rd       = w_rt;
        w_fused    = 1'b0;
        w_err      = w_ext_err;
        w_in_ready = !i_reset && w_slot_free;
        if (r_state == IDLE) begin
            // An accepted LUI is parked instead of emitted, waiting for a partner ORI
            w_capture = i_in_valid && w_in_ready && i_imm_mode == 3'(LUI);
            w_load    = i_in_valid && w_in_ready && !w_capture;
            w_next    = w_capture ? PEND : IDLE;
        end else begin
            // drain wins over a same-cycle match
            w_in_ready = w_in_ready && w_match && !i_drain;
            w_load     = w_in_ready || (!i_reset && w_slot_free && (i_drain || i_in_valid));
            w_val      = w_in_ready ? {r_upper[DATA_W-1:16], i_instruction[15:0]} : r_upper;
            w_rd       = r_prd;
            w_fused    = w_in_ready;
            w_err      = 1'b0;
            w_next     = w_load ? IDLE : PEND;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_upper <= '0;
            r_prd   <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_upper <= w_ext;
                r_prd   <= w_rt;
            end
        end
    end
`else
    logic w_unused;
    assign o_in_ready = !i_reset && w_slot_free;
    assign w_load     = i_in_valid && o_in_ready;
    assign w_val      = w_ext;
    assign w_rd       = w_rt;
    assign w_fused    = 1'b0;
    assign w_err      = w_ext_err;
    assign w_unused   = &{1'b0, i_drain};
`endif
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_imm   <= '0;
            r_rd    <= '0;
            r_fused <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_imm   <= w_val;
            r_rd    <= w_rd;
            r_fused <= w_fused;
            r_err   <= w_err;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign o_out_valid = r_valid;
    assign o_imm_out   = r_imm;
    assign o_out_rd    = r_rd;
    assign o_out_fused = r_fused;
    assign o_out_err   = r_err;
endmodule

// File: tb/tb_imm_unit.sv
// tb_imm_unit: directed plus randomized check of imm_unit against a behavioural model
module tb_imm_unit;
    localparam int DW = 32;
`ifdef LUI_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instr = '0;
    logic [2:0]    mode = '0;
    logic [DW-1:0] pc = '0;
    logic          drain = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] imm_out;
    logic [4:0]    out_rd;
    logic          out_fused;
    logic          out_err;
    int            errors = 0;
    int            checks = 0;

    logic          m_valid, m_fused, m_err, m_pend, exp_rdy;
    logic [DW-1:0] m_imm, m_up;
    logic [4:0]    m_rd, m_prd;

    imm_unit #(.DATA_W(DW)) dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_instruction(instr), .i_imm_mode(mode), .i_pc_plus4(pc), .i_drain(drain),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_imm_out(imm_out),
        .o_out_rd(out_rd), .o_out_fused(out_fused), .o_out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [DW-1:0] calc(input logic [31:0] ins, input logic [2:0] md, input logic [DW-1:0] p);
        longint s;
        logic [63:0] r, p64;
        s = longint'($signed(ins[15:0]));
        p64 = 64'(p);
        case (md)
            3'd0: r = s;
            3'd1: r = 64'(ins[15:0]);
            3'd2: r = s * 65536;
            3'd3: r = p64 + s * 4;
            3'd4: r = (p64 & ~64'h0FFF_FFFF) | (64'(ins[25:0]) * 4);
            default: r = 64'd0;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic m_match();
        return in_valid && instr[31:26] == 6'h0D && mode == 3'd1 && instr[25:21] == m_prd && instr[20:16] == m_prd;
    endfunction

    task automatic put(input logic [DW-1:0] v, input logic [4:0] rd, input logic f, input logic e);
        m_valid = 1'b1; m_imm = v; m_rd = rd; m_fused = f; m_err = e;
    endtask

    // Checks the DUT against the model, advances one clock, then steps the model
    task automatic tick();
        logic acc, free;
        #1;
        exp_rdy = !reset && (!m_valid || out_ready) && (!m_pend || (m_match() && !drain));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("imm_out", imm_out, m_imm);
            chk("out_rd", out_rd, m_rd);
            chk("out_fused", out_fused, m_fused);
            chk("out_err", out_err, m_err);
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_pend = 0; m_up = '0; m_prd = '0;
        end else begin
            acc = in_valid && exp_rdy;
            free = !m_valid || out_ready;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (!m_pend) begin
                if (acc && FUSE && mode == 3'd2) begin
                    m_pend = 1'b1; m_up = calc(instr, mode, pc); m_prd = instr[20:16];
                end else if (acc) put(calc(instr, mode, pc), instr[20:16], 1'b0, mode > 3'd4);
            end else if (acc) begin
                put((m_up & ~DW'(32'hFFFF)) | DW'(instr[15:0]), m_prd, 1'b1, 1'b0);
                m_pend = 1'b0;
            end else if (free && (drain || in_valid)) begin
                put(m_up, m_prd, 1'b0, 1'b0);
                m_pend = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] md, input logic [DW-1:0] p);
        in_valid = v; instr = ins; mode = md; pc = p;
    endtask

    initial begin
        int k;
        m_valid = 0; m_pend = 0; m_up = '0; m_prd = '0; m_imm = '0; m_rd = '0; m_fused = 0; m_err = 0;
        @(negedge clk);
        tick(); tick();
        chk("reset_valid", out_valid, 0);
        chk("reset_imm", imm_out, 0);
        chk("reset_rd", out_rd, 0);
        reset = 1'b0;
        drive(1, 32'h0000_8001, 3'd0, '0); tick();
        chk("sext_valid", out_valid, 1);
        chk("sext", imm_out, 32'hFFFF_8001);
        drive(1, 32'h0000_8001, 3'd1, '0); tick();
        chk("zext", imm_out, 32'h0000_8001);
        drive(1, 32'h0000_FFFF, 3'd3, 32'h0000_1000); tick();
        chk("branch", imm_out, 32'h0000_0FFC);
        drive(1, 32'h0000_0001, 3'd4, 32'h4000_0004); tick();
        chk("jump", imm_out, 32'h4000_0004);
        drive(1, 32'h0000_0123, 3'd0, '0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", imm_out, 32'h4000_0004);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next", imm_out, 32'h0000_0123);
        drive(1, mk(6'h3F, 5'd0, 5'd3, 16'h1234), 3'd7, '0); tick();
        chk("rsvd_imm", imm_out, 0);
        chk("rsvd_err", out_err, 1);
        chk("rsvd_rd", out_rd, 3);
`ifdef LUI_FUSE_EN
        drive(1, mk(6'h0F, 5'd0, 5'd8, 16'h1234), 3'd2, '0); tick();
        chk("lui_parked", out_valid, 0);
        drive(1, mk(6'h0D, 5'd8, 5'd8, 16'h5678), 3'd1, '0); tick();
        chk("fuse_imm", imm_out, 32'h1234_5678);
        chk("fuse_flag", out_fused, 1);
        chk("fuse_rd", out_rd, 8);
        drive(0, '0, 3'd0, '0); tick();
        chk("fuse_single", out_valid, 0);
        drive(1, mk(6'h0F, 5'd0, 5'd8, 16'h1234), 3'd2, '0); tick();
        drive(1, mk(6'h0D, 5'd9, 5'd9, 16'h5678), 3'd1, '0);
        #1 chk("mis_ready", in_ready, 0);
        tick();
        chk("mis_lui", imm_out, 32'h1234_0000);
        chk("mis_fused", out_fused, 0);
        tick();
        chk("mis_ori", imm_out, 32'h0000_5678);
        chk("mis_ori_rd", out_rd, 9);
        drive(1, mk(6'h0F, 5'd0, 5'd8, 16'h1234), 3'd2, '0); tick();
        drive(0, '0, 3'd0, '0); drain = 1'b1; tick(); drain = 1'b0;
        chk("drain_lui", imm_out, 32'h1234_0000);
        chk("drain_valid", out_valid, 1);
        drive(1, mk(6'h0F, 5'd0, 5'd8, 16'h1234), 3'd2, '0); tick();
        drive(0, '0, 3'd0, '0); reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_pend_valid", out_valid, 0);
        chk("rst_pend_imm", imm_out, 0);
        tick();
        chk("rst_pend_silent", out_valid, 0);
`else
        drive(1, mk(6'h0F, 5'd0, 5'd8, 16'h1234), 3'd2, '0); tick();
        chk("lui_plain", imm_out, 32'h1234_0000);
        chk("lui_unfused", out_fused, 0);
`endif
        drive(1, 32'h0000_0042, 3'd0, '0); out_ready = 1'b0; tick();
        reset = 1'b1; tick(); reset = 1'b0; out_ready = 1'b1;
        chk("rst_held_valid", out_valid, 0);
        chk("rst_held_imm", imm_out, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rg;
            rg = 5'(8 + $urandom_range(0, 1));
            k = $urandom_range(0, 3);
            reset = ($urandom_range(0, 63) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drain = ($urandom_range(0, 7) == 0);
            pc = DW'($urandom);
            if (k == 0) begin
                instr = $urandom; mode = 3'($urandom_range(0, 7));
            end else if (k == 1) begin
                instr = mk(6'h0F, 5'($urandom), rg, 16'($urandom)); mode = 3'd2;
            end else if (k == 2) begin
                instr = mk(6'h0D, rg, rg, 16'($urandom)); mode = 3'd1;
            end else begin
                instr = mk(6'h0D, 5'($urandom), 5'($urandom), 16'($urandom)); mode = 3'($urandom_range(0, 2));
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
